matrix_row_fetcher: RTL and testbench

Upstream read client of the single-port simple memory in the sum-stationary integration. On a start command it walks a matrix stored row-major at base + row*stride. It issues one element address per cycle on the memory's combinational read port and packs N consecutive elements into a vector. Each vector is handed to the compute array over a valid/ready stream, with a last flag on the final row.

---
 rtl/matrix_row_fetcher_pkg.sv | 13 +
 rtl/matrix_row_fetcher_if.sv | 33 +++
 rtl/matrix_row_fetcher.sv | 124 ++++++++++++
 tb/tb_matrix_row_fetcher.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/matrix_row_fetcher_pkg.sv
// Shared types and default sizes for the row fetcher and the compute array it feeds.
package matrix_row_fetcher_pkg;

  localparam int DEFAULT_N          = 4;
  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    OUTPUT
  } fetcher_state_t;

endpackage

// File: rtl/matrix_row_fetcher_if.sv
// Command, memory read port and vector stream of the row fetcher, bundled as one bus.
interface matrix_row_fetcher_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDRESS_BITS = 11,
  parameter int N            = 4,
  parameter int ROW_BITS     = 8
);

  logic                      start_valid;
  logic                      start_ready;
  logic [ADDRESS_BITS-1:0]   base_address;
  logic [ROW_BITS-1:0]       num_rows;
  logic [ADDRESS_BITS-1:0]   row_stride;
  logic [ADDRESS_BITS-1:0]   read_address;
  logic [DATA_WIDTH-1:0]     read_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [N*DATA_WIDTH-1:0]   out_data;
  logic                      out_last;
  logic                      done;

  // master is the fetcher itself; slave is the surrounding command source, memory and consumer
  modport master (
    input  start_valid, base_address, num_rows, row_stride, read_data, out_ready,
    output start_ready, read_address, out_valid, out_data, out_last, done
  );

  modport slave (
    output start_valid, base_address, num_rows, row_stride, read_data, out_ready,
    input  start_ready, read_address, out_valid, out_data, out_last, done
  );

endinterface

// File: rtl/matrix_row_fetcher.sv
// Walks a row-major matrix in memory, packing N elements per row into a vector
// and streaming each vector out with a last flag on the final row.
module matrix_row_fetcher
  import matrix_row_fetcher_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int SIZE         = 1024,
  parameter int ADDRESS_BITS = $clog2(SIZE + 1),
  parameter int N            = DEFAULT_N,
  parameter int ROW_BITS     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  matrix_row_fetcher_if.master  bus
);

  localparam int COL_BITS = (N > 1) ? $clog2(N) : 1;

  fetcher_state_t            state_q, state_d;
  logic [COL_BITS-1:0]       col_q, col_d;
  logic [ROW_BITS-1:0]       row_q, row_d;
  logic [ROW_BITS-1:0]       numRows_q, numRows_d;
  logic [ADDRESS_BITS-1:0]   stride_q, stride_d;
  logic [ADDRESS_BITS-1:0]   rowBase_q, rowBase_d;
  logic [N*DATA_WIDTH-1:0]   lanes_q, lanes_d;
  logic                      done_q, done_d;
  logic                      isLast;
  logic [ADDRESS_BITS-1:0]   readAddress;
  logic                      outValid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      numRows_q <= '0;
      stride_q  <= '0;
      rowBase_q <= '0;
      lanes_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      numRows_q <= numRows_d;
      stride_q  <= stride_d;
      rowBase_q <= rowBase_d;
      lanes_q   <= lanes_d;
      done_q    <= done_d;
    end
  end

  // numRows_q is never zero while in OUTPUT, so the subtraction cannot underflow there
  assign isLast = (row_q == numRows_q - ROW_BITS'(1));

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    numRows_d   = numRows_q;
    stride_d    = stride_q;
    rowBase_d   = rowBase_q;
    lanes_d     = lanes_q;
    done_d      = 1'b0;
    readAddress = '0;
    outValid    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start_valid) begin
          numRows_d = bus.num_rows;
          stride_d  = bus.row_stride;
          rowBase_d = bus.base_address;
          row_d     = '0;
          col_d     = '0;
          if (bus.num_rows == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = FETCH;
          end
        end
      end

      FETCH: begin
        readAddress = rowBase_q + ADDRESS_BITS'(col_q);
        for (int k = 0; k < N; k++) begin
          if (col_q == COL_BITS'(k)) begin
            lanes_d[k*DATA_WIDTH +: DATA_WIDTH] = bus.read_data;
          end
        end
        if (col_q == COL_BITS'(N - 1)) begin
          col_d   = '0;
          state_d = OUTPUT;
        end else begin
          col_d = col_q + COL_BITS'(1);
        end
      end

      OUTPUT: begin
        outValid = 1'b1;
        if (bus.out_ready) begin
          if (isLast) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            row_d     = row_q + ROW_BITS'(1);
            rowBase_d = rowBase_q + stride_q;
            state_d   = FETCH;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.start_ready  = (state_q == IDLE) && !reset;
  assign bus.read_address = readAddress;
  assign bus.out_valid    = outValid;
  assign bus.out_last     = outValid && isLast;
  assign bus.out_data     = lanes_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_matrix_row_fetcher.sv
// Self-checking bench for matrix_row_fetcher: directed scenarios plus randomized
// commands compared against a memory-walk reference model.
module tb_matrix_row_fetcher;

  localparam int DW       = 8;
  localparam int SIZE     = 1024;
  localparam int AB       = $clog2(SIZE + 1);
  localparam int N        = 4;
  localparam int RB       = 8;
  localparam int MEMDEPTH = 1 << AB;
  localparam int AMASK    = MEMDEPTH - 1;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  logic [DW-1:0] mem [0:MEMDEPTH-1];

  matrix_row_fetcher_if #(.DATA_WIDTH(DW), .ADDRESS_BITS(AB), .N(N), .ROW_BITS(RB)) busIf ();

  matrix_row_fetcher #(
    .DATA_WIDTH(DW), .SIZE(SIZE), .ADDRESS_BITS(AB), .N(N), .ROW_BITS(RB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (busIf)
  );

  // combinational memory read port, standing in for simple_memory
  assign busIf.read_data = mem[busIf.read_address];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
    end
  endtask

  task automatic fillIdentity();
    for (int a = 0; a < MEMDEPTH; a++) mem[a] = DW'(a);
  endtask

  // Drives one command and checks every cycle until it completes.
  task automatic applyStimulus(input string tag, input int base, input int rows,
                               input int stride, input int stallMax, input bit pokeBusy);
    logic [N*DW-1:0] expVec;
    int rowBase;
    int stall;
    busIf.start_valid  = 1'b1;
    busIf.base_address = AB'(base);
    busIf.num_rows     = RB'(rows);
    busIf.row_stride   = AB'(stride);
    checkOutput({tag, ".start_ready"}, busIf.start_ready, 1);
    @(negedge clk);
    busIf.start_valid  = 1'b0;
    busIf.base_address = AB'($urandom);
    busIf.num_rows     = RB'($urandom);
    busIf.row_stride   = AB'($urandom);
    if (rows == 0) begin
      checkOutput({tag, ".zero_done"}, busIf.done, 1);
      checkOutput({tag, ".zero_ready"}, busIf.start_ready, 1);
      checkOutput({tag, ".zero_valid"}, busIf.out_valid, 0);
      @(negedge clk);
      checkOutput({tag, ".zero_done_end"}, busIf.done, 0);
      checkOutput({tag, ".zero_valid_end"}, busIf.out_valid, 0);
      return;
    end
    for (int r = 0; r < rows; r++) begin
      rowBase = (base + r * stride) & AMASK;
      for (int k = 0; k < N; k++) begin
        checkOutput($sformatf("%s.addr r%0d k%0d", tag, r, k), busIf.read_address,
                    (rowBase + k) & AMASK);
        checkOutput($sformatf("%s.fetch_valid r%0d", tag, r), busIf.out_valid, 0);
        checkOutput($sformatf("%s.fetch_ready r%0d", tag, r), busIf.start_ready, 0);
        expVec[k*DW +: DW] = mem[(rowBase + k) & AMASK];
        @(negedge clk);
      end
      stall = (stallMax > 0) ? $urandom_range(0, stallMax) : 0;
      busIf.out_ready = 1'b0;
      for (int s = 0; s <= stall; s++) begin
        if (s == stall) busIf.out_ready = 1'b1;
        if (pokeBusy && r == 0 && s == 0) busIf.start_valid = 1'b1;
        checkOutput($sformatf("%s.valid r%0d s%0d", tag, r, s), busIf.out_valid, 1);
        checkOutput($sformatf("%s.data r%0d s%0d", tag, r, s), busIf.out_data, expVec);
        checkOutput($sformatf("%s.last r%0d s%0d", tag, r, s), busIf.out_last, r == rows - 1);
        checkOutput($sformatf("%s.out_addr r%0d s%0d", tag, r, s), busIf.read_address, 0);
        checkOutput($sformatf("%s.busy_ready r%0d s%0d", tag, r, s), busIf.start_ready, 0);
        @(negedge clk);
      end
      busIf.start_valid = 1'b0;
      busIf.out_ready   = 1'($urandom_range(0, 1));
    end
    checkOutput({tag, ".done"}, busIf.done, 1);
    checkOutput({tag, ".end_ready"}, busIf.start_ready, 1);
    checkOutput({tag, ".end_valid"}, busIf.out_valid, 0);
    busIf.out_ready = 1'b0;
    @(negedge clk);
    checkOutput({tag, ".done_pulse"}, busIf.done, 0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    busIf.start_valid  = 1'b0;
    busIf.base_address = '0;
    busIf.num_rows     = '0;
    busIf.row_stride   = '0;
    busIf.out_ready    = 1'b0;
    fillIdentity();

    repeat (2) @(negedge clk);
    checkOutput("rst.valid", busIf.out_valid, 0);
    checkOutput("rst.last", busIf.out_last, 0);
    checkOutput("rst.done", busIf.done, 0);
    checkOutput("rst.data", busIf.out_data, 0);
    checkOutput("rst.addr", busIf.read_address, 0);
    checkOutput("rst.ready", busIf.start_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle.ready", busIf.start_ready, 1);

    $display("[TB] basic two-row fetch");
    applyStimulus("basic", 16, 2, 8, 0, 1'b0);

    $display("[TB] backpressure");
    applyStimulus("bp", 16, 2, 8, 5, 1'b0);

    $display("[TB] zero rows");
    applyStimulus("zero", 100, 0, 3, 0, 1'b0);

    $display("[TB] address wrap");
    applyStimulus("wrap", 2046, 1, 5, 0, 1'b0);

    $display("[TB] start while busy");
    applyStimulus("busy", 40, 3, 100, 2, 1'b1);

    $display("[TB] reset mid-fetch");
    busIf.start_valid  = 1'b1;
    busIf.base_address = AB'(300);
    busIf.num_rows     = RB'(2);
    busIf.row_stride   = AB'(4);
    @(negedge clk);
    busIf.start_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midrst.valid", busIf.out_valid, 0);
    checkOutput("midrst.addr", busIf.read_address, 0);
    checkOutput("midrst.done", busIf.done, 0);
    checkOutput("midrst.ready", busIf.start_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midrst.done_after", busIf.done, 0);
    checkOutput("midrst.ready_after", busIf.start_ready, 1);
    checkOutput("midrst.valid_after", busIf.out_valid, 0);
    applyStimulus("after_rst", 500, 2, 12, 1, 1'b0);

    $display("[TB] randomized commands");
    for (int a = 0; a < MEMDEPTH; a++) mem[a] = DW'($urandom);
    for (int i = 0; i < 8; i++) begin
      applyStimulus($sformatf("rand%0d", i), int'($urandom_range(0, AMASK)),
                    int'($urandom_range(0, 4)), int'($urandom_range(0, AMASK)), 3,
                    1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
